// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for the unified memory of the multicycle ARM core: core (M0) vs debug/loader (M1).
// Optional build macro ARB_LOCK_EN adds m1_lock, which lets M1 hold the memory across cycles.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_adr,
  input  logic [DATA_W-1:0] m0_wd,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rd,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_adr,
  input  logic [DATA_W-1:0] m1_wd,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rd,
`ifdef ARB_LOCK_EN
  input  logic              m1_lock,
`endif
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wd,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rd
);

  typedef enum logic [1:0] {
    OWN_NONE      = 2'd0,
    OWN_M0        = 2'd1,
    OWN_M1        = 2'd2
`ifdef ARB_LOCK_EN
    , OWN_M1_LOCKED = 2'd3
`endif
  } owner_t;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  owner_t            owner;
  owner_t            owner_next;
  logic [7:0]        wait_cnt;
  logic [ADDR_W-1:0] hold_adr;
  logic [DATA_W-1:0] hold_wd;
  logic              locked;

`ifdef ARB_LOCK_EN
  assign locked = (owner == OWN_M1_LOCKED);
`else
  assign locked = 1'b0;
`endif

  // Core has priority until M1 has been starved for MAX_WAIT cycles; reset low kills every grant.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (reset) begin
      if (locked)
        m1_gnt = m1_req;
      else if (m1_req && (!m0_req || wait_cnt == MAX_WAIT_C))
        m1_gnt = 1'b1;
      else
        m0_gnt = m0_req;
    end
  end

  always_comb begin
    owner_next = OWN_NONE;
    if (m0_gnt)
      owner_next = OWN_M0;
    else if (m1_gnt)
      owner_next = OWN_M1;
`ifdef ARB_LOCK_EN
    if ((m1_gnt || locked) && m1_lock)
      owner_next = OWN_M1_LOCKED;
`endif
  end

  // The current grant steers the memory; when idle the previous owner's bus is shown, else the last value is held.
  always_comb begin
    mem_adr = hold_adr;
    mem_wd  = hold_wd;
    mem_we  = 1'b0;
    if (m0_gnt) begin
      mem_adr = m0_adr;
      mem_wd  = m0_wd;
      mem_we  = m0_we;
    end else if (m1_gnt) begin
      mem_adr = m1_adr;
      mem_wd  = m1_wd;
      mem_we  = m1_we;
    end else begin
      case (owner)
        OWN_M0: begin
          mem_adr = m0_adr;
          mem_wd  = m0_wd;
        end
        OWN_M1: begin
          mem_adr = m1_adr;
          mem_wd  = m1_wd;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner     <= OWN_NONE;
      wait_cnt  <= 8'd0;
      hold_adr  <= '0;
      hold_wd   <= '0;
      m0_rvalid <= 1'b0;
      m0_rd     <= '0;
      m1_rvalid <= 1'b0;
      m1_rd     <= '0;
    end else begin
      owner    <= owner_next;
      hold_adr <= mem_adr;
      hold_wd  <= mem_wd;

      if (locked || !m1_req || m1_gnt)
        wait_cnt <= 8'd0;
      else if (wait_cnt != MAX_WAIT_C)
        wait_cnt <= wait_cnt + 8'd1;

      m0_rvalid <= m0_gnt && !m0_we;
      if (m0_gnt && !m0_we)
        m0_rd <= mem_rd;

      m1_rvalid <= m1_gnt && !m1_we;
      if (m1_gnt && !m1_we)
        m1_rd <= mem_rd;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small word memory behind it.
// Build with ARB_LOCK_EN defined to also exercise the M1 lock sequence.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_adr, m0_wd, m1_adr, m1_wd;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rd, m1_rd;
  logic [31:0] mem_adr, mem_wd, mem_rd;
  logic        mem_we;
`ifdef ARB_LOCK_EN
  logic        m1_lock = 1'b0;
`endif

  logic [31:0] mem [0:255];
  int          write_count = 0;
  int          vec_count   = 0;
  int          miss_count  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(8)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_adr(m0_adr), .m0_wd(m0_wd),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rd(m0_rd),
    .m1_req(m1_req), .m1_we(m1_we), .m1_adr(m1_adr), .m1_wd(m1_wd),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rd(m1_rd),
`ifdef ARB_LOCK_EN
    .m1_lock(m1_lock),
`endif
    .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
  );

  assign mem_rd = mem[mem_adr[9:2]];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_adr[9:2]] <= mem_wd;
      write_count <= write_count + 1;
    end
  end

  typedef struct {
    string       name;
    logic        m0_req, m0_we;
    logic [31:0] m0_adr, m0_wd;
    logic        m1_req, m1_we;
    logic [31:0] m1_adr, m1_wd;
    logic        exp_m0_gnt, exp_m1_gnt, exp_mem_we;
    logic        exp_m0_rvalid;
    logic [31:0] exp_m0_rd;
    logic        exp_m1_rvalid;
    logic [31:0] exp_m1_rd;
  } vec_t;

  vec_t vecs [13];

  task automatic applyStimulus(input vec_t v);
    m0_req = v.m0_req; m0_we = v.m0_we; m0_adr = v.m0_adr; m0_wd = v.m0_wd;
    m1_req = v.m1_req; m1_we = v.m1_we; m1_adr = v.m1_adr; m1_wd = v.m1_wd;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic setIdle();
    m0_req = 1'b0; m0_we = 1'b0; m0_adr = '0; m0_wd = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_adr = '0; m1_wd = '0;
  endtask

  initial begin
    vecs[0]  = '{"m1 preload 0x8",   0,0,32'h0,32'h0,        1,1,32'h8,32'hE2800001,   0,1,1, 0,32'h0,        0,32'h0};
    vecs[1]  = '{"m0 rd 0x8",        1,0,32'h8,32'h0,        0,0,32'h0,32'h0,          1,0,0, 0,32'h0,        0,32'h0};
    vecs[2]  = '{"m0 rvalid 0x8",    0,0,32'h0,32'h0,        0,0,32'h0,32'h0,          0,0,0, 1,32'hE2800001, 0,32'h0};
    vecs[3]  = '{"m1 wr 0x100",      0,0,32'h0,32'h0,        1,1,32'h100,32'h1,        0,1,1, 0,32'hE2800001, 0,32'h0};
    vecs[4]  = '{"m0 rd 0x100",      1,0,32'h100,32'h0,      0,0,32'h0,32'h0,          1,0,0, 0,32'hE2800001, 0,32'h0};
    vecs[5]  = '{"m0 rvalid 0x100",  0,0,32'h0,32'h0,        0,0,32'h0,32'h0,          0,0,0, 1,32'h1,        0,32'h0};
    vecs[6]  = '{"m1 rd 0x40",       0,0,32'h0,32'h0,        1,0,32'h40,32'h0,         0,1,0, 0,32'h1,        0,32'h0};
    vecs[7]  = '{"m1 rvalid 0x40",   0,0,32'h0,32'h0,        0,0,32'h0,32'h0,          0,0,0, 0,32'h1,        1,32'h0000DEAD};
    vecs[8]  = '{"both req m0 wins", 1,0,32'h8,32'h0,        1,0,32'h100,32'h0,        1,0,0, 0,32'h1,        0,32'h0000DEAD};
    vecs[9]  = '{"m1 alone",         0,0,32'h0,32'h0,        1,0,32'h100,32'h0,        0,1,0, 1,32'hE2800001, 0,32'h0000DEAD};
    vecs[10] = '{"m0 wr 0x8",        1,1,32'h8,32'h55,       0,0,32'h0,32'h0,          1,0,1, 0,32'hE2800001, 1,32'h1};
    vecs[11] = '{"m0 rd back 0x8",   1,0,32'h8,32'h0,        0,0,32'h0,32'h0,          1,0,0, 0,32'hE2800001, 0,32'h1};
    vecs[12] = '{"m0 rvalid 0x55",   0,0,32'h0,32'h0,        0,0,32'h0,32'h0,          0,0,0, 1,32'h55,       0,32'h1};

    // Reset held low while the core tries to write.
    reset = 1'b0;
    setIdle();
    repeat (2) @(posedge clk);
    #1;
    m0_req = 1'b1; m0_we = 1'b1; m0_adr = 32'h40; m0_wd = 32'h0000DEAD;
    #1;
    checkOutput("rst m0_gnt",    32'(m0_gnt),    32'h0);
    checkOutput("rst m1_gnt",    32'(m1_gnt),    32'h0);
    checkOutput("rst mem_we",    32'(mem_we),    32'h0);
    checkOutput("rst m0_rvalid", 32'(m0_rvalid), 32'h0);
    checkOutput("rst m1_rvalid", 32'(m1_rvalid), 32'h0);
    checkOutput("rst m0_rd",     m0_rd,          32'h0);
    checkOutput("rst m1_rd",     m1_rd,          32'h0);
    @(posedge clk);
    #1;
    checkOutput("rst no write", 32'(write_count), 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("release m0_gnt", 32'(m0_gnt), 32'h1);
    checkOutput("release mem_we", 32'(mem_we), 32'h1);

    for (int i = 0; i < 13; i++) begin
      @(posedge clk);
      #1;
      applyStimulus(vecs[i]);
      #1;
      checkOutput({vecs[i].name, " m0_gnt"},    32'(m0_gnt),    32'(vecs[i].exp_m0_gnt));
      checkOutput({vecs[i].name, " m1_gnt"},    32'(m1_gnt),    32'(vecs[i].exp_m1_gnt));
      checkOutput({vecs[i].name, " mem_we"},    32'(mem_we),    32'(vecs[i].exp_mem_we));
      checkOutput({vecs[i].name, " m0_rvalid"}, 32'(m0_rvalid), 32'(vecs[i].exp_m0_rvalid));
      checkOutput({vecs[i].name, " m0_rd"},     m0_rd,          vecs[i].exp_m0_rd);
      checkOutput({vecs[i].name, " m1_rvalid"}, 32'(m1_rvalid), 32'(vecs[i].exp_m1_rvalid));
      checkOutput({vecs[i].name, " m1_rd"},     m1_rd,          vecs[i].exp_m1_rd);
    end
    checkOutput("total writes", 32'(write_count), 32'd4);

    // Both masters held busy: M1 should win exactly on every ninth cycle.
    for (int c = 1; c <= 18; c++) begin
      @(posedge clk);
      #1;
      m0_req = 1'b1; m0_we = 1'b0; m0_adr = 32'h8;
      m1_req = 1'b1; m1_we = 1'b0; m1_adr = 32'h100;
      #1;
      checkOutput($sformatf("starve c%0d m0_gnt", c), 32'(m0_gnt), (c % 9 == 0) ? 32'h0 : 32'h1);
      checkOutput($sformatf("starve c%0d m1_gnt", c), 32'(m1_gnt), (c % 9 == 0) ? 32'h1 : 32'h0);
    end
    @(posedge clk);
    #1;
    setIdle();

    // Reset dropped in the same cycle as an M1 read grant.
    @(posedge clk);
    #1;
    m1_req = 1'b1; m1_we = 1'b0; m1_adr = 32'h40;
    #1;
    checkOutput("midrst pre m1_gnt", 32'(m1_gnt), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midrst m1_gnt", 32'(m1_gnt), 32'h0);
    checkOutput("midrst mem_we", 32'(mem_we), 32'h0);
    @(posedge clk);
    #1;
    checkOutput("midrst m1_rvalid", 32'(m1_rvalid), 32'h0);
    checkOutput("midrst m1_rd",     m1_rd,          32'h0);
    checkOutput("midrst m0_rd",     m0_rd,          32'h0);
    checkOutput("midrst m0_rvalid", 32'(m0_rvalid), 32'h0);
    setIdle();
    reset = 1'b1;

`ifdef ARB_LOCK_EN
    // M1 takes the lock, then the core is shut out until the lock drops.
    @(posedge clk);
    #1;
    m1_req = 1'b1; m1_we = 1'b0; m1_adr = 32'h8; m1_lock = 1'b1;
    #1;
    checkOutput("lock take m1_gnt", 32'(m1_gnt), 32'h1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      m0_req = 1'b1; m0_adr = 32'h100;
      m1_req = (k < 2);
      #1;
      checkOutput($sformatf("locked k%0d m0_gnt", k), 32'(m0_gnt), 32'h0);
    end
    @(posedge clk);
    #1;
    m1_lock = 1'b0; m1_req = 1'b0;
    #1;
    checkOutput("unlock cycle m0_gnt", 32'(m0_gnt), 32'h0);
    @(posedge clk);
    #1;
    checkOutput("after unlock m0_gnt", 32'(m0_gnt), 32'h1);
    setIdle();
`endif

    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
